seg_scan_ctrl: RTL and testbench

//  Scan controller for the vending machine's 4-digit multiplexed 7-segment display.
//  The left field (an[3:2]) shows price, 0..99. The right field (an[1:0]) shows credit or change, 0..99.
//  One combinational tens/ones splitter is time-shared between both fields, one digit slot at a time.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/bcd_split.sv | 15 +
 rtl/seg_scan_ctrl.sv | 95 +++++++++
 tb/tb_seg_scan_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment encodings, slot map, scan state and shadow register layout
package seg_pkg;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [1:0] SLOT_R1  = 2'd0;
    localparam logic [1:0] SLOT_R10 = 2'd1;
    localparam logic [1:0] SLOT_L1  = 2'd2;
    localparam logic [1:0] SLOT_L10 = 2'd3;
    typedef enum logic {DEAD, DRIVE} scan_state_e;
    typedef struct packed {
        logic [7:0] left;
        logic [7:0] right;
        logic       blank_l;
        logic       blank_r;
        logic       blink_r;
    } shadow_t;
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        return d > 4'd9 ? SEG_OFF : SEG_DIGIT[d];
    endfunction
endpackage

// File: rtl/bcd_split.sv
// bcd_split: combinational tens/ones splitter for 0..255 with overflow flag above 99
//   v_i     value to split
//   tens_o  v_i/10 (only meaningful when ovf_o is low)
//   ones_o  v_i%10
//   ovf_o   v_i > 99
module bcd_split (
    input  logic [7:0] v_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       ovf_o
);
    assign tens_o = 4'(v_i / 8'd10);
    assign ones_o = 4'(v_i % 8'd10);
    assign ovf_o  = v_i > 8'd99;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller (price left, credit right)
//   clk, rst_n                 clock, async active-low reset
//   val_left/val_right         field values, captured once per frame
//   blank_left/blank_right     darken a field
//   blink_right                blink the right field
//   an, seg                    active-low anodes and segments {g..a}, registered
//   frame_start                pulse on the cycle new shadow values take effect
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYC     = 4,
    parameter int BLINK_FRAMES = 125,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] val_left,
    input  logic [7:0] val_right,
    input  logic       blank_left,
    input  logic       blank_right,
    input  logic       blink_right,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [CW-1:0] cnt_q;
    logic [1:0]    slot_q;
    scan_state_e   state_q;
    logic [FW-1:0] frame_q;
    logic          blink_q;
    shadow_t       sh_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          fs_q;
    logic          tick, boundary, frame_wrap, left, tens_slot, dark, lz_blank, ovf;
    logic [7:0]    operand;
    logic [3:0]    tens, ones, digit;

    assign tick       = cnt_q == CW'(REFRESH_DIV - 1);
    assign boundary   = tick && slot_q == SLOT_L10;
    assign frame_wrap = frame_q == FW'(BLINK_FRAMES - 1);

    bcd_split u_split (
        .v_i   (operand),
        .tens_o(tens),
        .ones_o(ones),
        .ovf_o (ovf)
    );

    // Overrides in priority order: field dark, then overflow dash, then leading-zero blank
    always_comb begin
        left      = slot_q == SLOT_L1 || slot_q == SLOT_L10;
        tens_slot = slot_q == SLOT_R10 || slot_q == SLOT_L10;
        operand   = left ? sh_q.left : sh_q.right;
        digit     = tens_slot ? tens : ones;
        dark      = left ? sh_q.blank_l : (sh_q.blank_r || (sh_q.blink_r && blink_q));
        lz_blank  = LZ_SUPPRESS && tens_slot && !ovf && tens == 4'd0;
        an_d      = (state_q == DEAD || dark || lz_blank) ? AN_OFF : ~(4'b0001 << slot_q);
        seg_d     = an_d == AN_OFF ? SEG_OFF : ovf ? SEG_DASH : seg_encode(digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            slot_q  <= SLOT_R1;
            state_q <= DEAD;
            frame_q <= '0;
            blink_q <= 1'b0;
            sh_q    <= '{left: 8'd0, right: 8'd0, blank_l: 1'b1, blank_r: 1'b1, blink_r: 1'b0};
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            slot_q  <= tick ? slot_q + 2'd1 : slot_q;
            state_q <= tick ? DEAD : cnt_q == CW'(DEAD_CYC - 1) ? DRIVE : state_q;
            if (boundary) begin
                sh_q    <= '{left: val_left, right: val_right, blank_l: blank_left,
                             blank_r: blank_right, blink_r: blink_right};
                frame_q <= frame_wrap ? '0 : frame_q + 1'b1;
                blink_q <= blink_q ^ frame_wrap;
            end
            fs_q  <= boundary;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized bench against a frame/slot arithmetic reference model
module tb_seg_scan_ctrl;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;
    localparam logic [6:0] DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk = 1'b0, rst_n = 1'b0, chk_en = 1'b0;
    logic [7:0] val_left = 8'd0, val_right = 8'd0;
    logic       blank_left = 1'b0, blank_right = 1'b0, blink_right = 1'b0;
    logic [3:0] an, an_nl;
    logic [6:0] seg, seg_nl;
    logic       frame_start, fs_nl;
    int         checks = 0, fails = 0;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .DEAD_CYC(DEAD), .BLINK_FRAMES(BF), .LZ_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .val_left(val_left), .val_right(val_right),
        .blank_left(blank_left), .blank_right(blank_right), .blink_right(blink_right),
        .an(an), .seg(seg), .frame_start(frame_start)
    );
    seg_scan_ctrl #(.REFRESH_DIV(DIV), .DEAD_CYC(DEAD), .BLINK_FRAMES(BF), .LZ_SUPPRESS(1'b0)) dut_nl (
        .clk(clk), .rst_n(rst_n), .val_left(val_left), .val_right(val_right),
        .blank_left(blank_left), .blank_right(blank_right), .blink_right(blink_right),
        .an(an_nl), .seg(seg_nl), .frame_start(fs_nl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int   e;
    int   sh_l, sh_r;
    bit   sh_bl, sh_br, sh_bk;
    logic [3:0] x_an, x_an_nl;
    logic [6:0] x_seg, x_seg_nl;
    logic x_fs;
    bit   x_care, x_care_nl;

    // Output expected one cycle after k elapsed cycles since reset release
    function automatic void predict(input int k, input bit lz, output logic [3:0] a,
                                    output logic [6:0] s, output bit care);
        int slot = (k / DIV) % 4;
        int f    = k / FRAME;
        int v    = slot >= 2 ? sh_l : sh_r;
        bit dead = (k % DIV) < DEAD;
        bit dark = slot >= 2 ? sh_bl : (sh_br || (sh_bk && (f / BF) % 2 == 1));
        bit tens = slot % 2 == 1;
        bit lzb  = lz && tens && v < 10;
        care = dead || !(dark || lzb);
        if (dead || dark || lzb) begin
            a = 4'hF;
            s = 7'h7F;
        end else begin
            a = 4'hF ^ (4'h1 << slot);
            s = v > 99 ? 7'b0111111 : DIGITS[tens ? v / 10 : v % 10];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; sh_l = 0; sh_r = 0; sh_bl = 1; sh_br = 1; sh_bk = 0;
            x_an = 4'hF; x_an_nl = 4'hF; x_seg = 7'h7F; x_seg_nl = 7'h7F;
            x_fs = 1'b0; x_care = 1; x_care_nl = 1;
        end else begin
            predict(e, 1'b1, x_an, x_seg, x_care);
            predict(e, 1'b0, x_an_nl, x_seg_nl, x_care_nl);
            x_fs = (e % FRAME) == FRAME - 1;
            if (x_fs) begin
                sh_l = val_left; sh_r = val_right;
                sh_bl = blank_left; sh_br = blank_right; sh_bk = blink_right;
            end
            e++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", an, x_an);
            check("an_nolz", an_nl, x_an_nl);
            if (x_care) check("seg", seg, x_seg);
            if (x_care_nl) check("seg_nolz", seg_nl, x_seg_nl);
            check("frame_start", frame_start, x_fs);
            check("onehot", 32'($countones(~an) <= 1), 32'd1);
            check("onehot_nolz", 32'($countones(~an_nl) <= 1), 32'd1);
        end
    end

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_val();
        return $urandom_range(0, 3) == 0 ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
    endfunction

    initial begin
        int n;
        bit seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        val_left = 8'd95; val_right = 8'd25;
        frames(3);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_fs", frame_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            n++;
            #1 seen = frame_start;
        end
        check("fs_latency", n, 32);
        @(negedge clk);
        frames(2);
        repeat (DIV + 3) @(negedge clk);
        val_right = 8'd40;
        frames(2);
        val_right = 8'd7;    frames(2);
        val_left  = 8'd150;  frames(2);
        val_left  = 8'd99;   frames(2);
        val_left  = 8'd100;  frames(2);
        val_left  = 8'd255;  frames(2);
        val_left  = 8'd5;    val_right = 8'd25; blink_right = 1'b1;
        frames(8);
        blink_right = 1'b0;  blank_left = 1'b1; frames(2);
        blank_left = 1'b0;   blank_right = 1'b1; frames(2);
        blank_right = 1'b0;
        repeat (60 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: val_left = rand_val();
                    1: val_right = rand_val();
                    2: blank_left = $urandom_range(0, 5) == 0;
                    3: blank_right = $urandom_range(0, 5) == 0;
                    default: blink_right = $urandom_range(0, 1) == 1;
                endcase
            end
        end
        frames(1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
